// File: rtl/nibble_pack_fifo_pkg.sv
// Shared types for the nibble packer; NIBBLE_PACK_PARITY_EN widens FIFO words to carry
// a parity bit computed at push time.
package nibble_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [7:0] byte_t;

  typedef enum logic {
    PK_EMPTY = 1'b0,
    PK_HALF  = 1'b1
  } pack_state_e;

  localparam nibble_t PAD_NIBBLE = 4'h0;

`ifdef NIBBLE_PACK_PARITY_EN
  localparam int FIFO_W = 9;
`else
  localparam int FIFO_W = 8;
`endif

  function automatic logic [FIFO_W-1:0] fifo_word(input byte_t b);
`ifdef NIBBLE_PACK_PARITY_EN
    return {^b, b};
`else
    return b;
`endif
  endfunction

endpackage

// File: rtl/nibble_pack_fifo_if.sv
// Nibble-in / byte-out handshake bundle; out_parity exists only with NIBBLE_PACK_PARITY_EN.
interface nibble_pack_fifo_if #(
  parameter int DEPTH = 4
);
  import nibble_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  nibble_t       in_data;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  byte_t         out_data;
  logic          out_ready;
  logic [LW-1:0] level;
`ifdef NIBBLE_PACK_PARITY_EN
  logic          out_parity;

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, level, out_parity
  );
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, level, out_parity
  );
`else
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, level
  );
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, level
  );
`endif
endinterface

// File: rtl/nibble_pack_fifo_fifo.sv
// Synchronous FIFO, one-cycle push-to-head latency; full/empty derived from occupancy.
// Storage is not reset -- consumers must gate head_o with empty_o.
module nib_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/nibble_pack_fifo.sv
// Packs nibble pairs (first -> [3:0]) into a byte FIFO; byte at head the cycle after the
// second nibble. in_ready uses registered full only. Parity option: NIBBLE_PACK_PARITY_EN.
module nibble_pack_fifo
  import nibble_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  nibble_pack_fifo_if.slave bus
);
  pack_state_e       state_q, state_d;
  nibble_t           low_q, low_d;
  logic              flush_pend_q, flush_pend_d;

  logic              full, empty;
  logic              in_ready, in_fire, pop;
  logic              push;
  byte_t             push_byte;
  logic [FIFO_W-1:0] head;

  assign in_ready = ~flush_pend_q & ((state_q == PK_EMPTY) | ~full);
  assign in_fire  = bus.in_valid & in_ready;
  assign pop      = ~empty & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= PK_EMPTY;
      low_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      low_q        <= low_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // A pending flush behaves like a flush request that repeats until space opens up.
  always_comb begin
    state_d      = state_q;
    low_d        = low_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      PK_EMPTY: begin
        if (in_fire) begin
          state_d = PK_HALF;
          low_d   = bus.in_data;
        end
      end
      PK_HALF: begin
        if (in_fire) begin
          state_d = PK_EMPTY;
        end else if (bus.flush | flush_pend_q) begin
          if (!full) begin
            state_d      = PK_EMPTY;
            flush_pend_d = 1'b0;
          end else begin
            flush_pend_d = 1'b1;
          end
        end
      end
      default: state_d = PK_EMPTY;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_byte = {bus.in_data, low_q};
    if (state_q == PK_HALF) begin
      if (in_fire) begin
        push = 1'b1;
      end else if ((bus.flush | flush_pend_q) & ~full) begin
        push      = 1'b1;
        push_byte = {PAD_NIBBLE, low_q};
      end
    end
  end

  nib_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i (fifo_word(push_byte)),
    .pop_i      (pop),
    .head_o     (head),
    .level_o    (bus.level),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? 8'h00 : head[7:0];
`ifdef NIBBLE_PACK_PARITY_EN
  assign bus.out_parity = ~empty & head[8];
`endif

endmodule

// File: tb/tb_nibble_pack_fifo.sv
// Bench for nibble_pack_fifo: randomized traffic against a queue-based reference model.
module tb_nibble_pack_fifo;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst_n;

  nibble_pack_fifo_if #(.DEPTH(DEPTH)) bus ();

  nibble_pack_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tot = 0;
  int bad = 0;

  // Reference model: bytes queued in the FIFO, the held low nibble, a pending flush.
  logic [7:0] mq[$];
  logic [7:0] popped_q[$];
  logic [3:0] acc_q[$];
  bit         m_half;
  logic [3:0] m_low;
  bit         m_pend;

  logic          obs_vld, obs_rdy, obs_par;
  logic [7:0]    obs_dat;
  logic [LW-1:0] obs_lvl;
  logic          exp_vld, exp_rdy, exp_par;
  logic [7:0]    exp_dat;
  logic [LW-1:0] exp_lvl;
  bit            last_in_fire, last_out_fire, last_push;

  task automatic model_clear();
    mq.delete();
    m_half = 0;
    m_low  = 4'h0;
    m_pend = 0;
  endtask

  // Called #1 after a rising edge: sample, drive, advance the model, wait one cycle.
  task automatic step(input bit v, input logic [3:0] d, input bit fl, input bit ordy);
    bit was_full;
    obs_vld = bus.out_valid;
    obs_rdy = bus.in_ready;
    obs_dat = bus.out_data;
    obs_lvl = bus.level;
`ifdef NIBBLE_PACK_PARITY_EN
    obs_par = bus.out_parity;
`else
    obs_par = 1'b0;
`endif
    exp_lvl = LW'(mq.size());
    exp_vld = (mq.size() != 0);
    exp_dat = exp_vld ? mq[0] : 8'h00;
    exp_par = ^exp_dat;
    exp_rdy = !m_pend && (!m_half || mq.size() < DEPTH);

    bus.in_valid  = v;
    bus.in_data   = d;
    bus.flush     = fl;
    bus.out_ready = ordy;

    was_full      = (mq.size() == DEPTH);
    last_in_fire  = v && exp_rdy;
    last_out_fire = exp_vld && ordy;
    last_push     = 0;
    if (last_out_fire) popped_q.push_back(mq.pop_front());
    if (last_in_fire) begin
      acc_q.push_back(d);
      if (m_half) begin
        mq.push_back({d, m_low});
        m_half    = 0;
        last_push = 1;
      end else begin
        m_half = 1;
        m_low  = d;
      end
    end else if (m_half && (m_pend || fl)) begin
      if (!was_full) begin
        mq.push_back({4'h0, m_low});
        m_half    = 0;
        m_pend    = 0;
        last_push = 1;
      end else begin
        m_pend = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h3;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      tot++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      tot++; if (bus.level !== '0) begin bad++; $display("FAIL reset_level: got %0d want 0", bus.level); end
      tot++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      tot++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    model_clear();
  endtask

  task automatic test_pack();
    step(1, 4'h5, 0, 1);
    step(1, 4'hA, 0, 1);
    tot++; if (obs_vld !== 1'b0) begin bad++; $display("FAIL pack_early_valid: got %b want 0", obs_vld); end
    step(0, 4'h0, 0, 1);
    tot++; if (obs_vld !== 1'b1) begin bad++; $display("FAIL pack_valid: got %b want 1", obs_vld); end
    tot++; if (obs_dat !== 8'hA5) begin bad++; $display("FAIL pack_byte: got %h want a5", obs_dat); end
    step(0, 4'h0, 0, 1);
    tot++; if (obs_vld !== 1'b0 || obs_lvl !== '0) begin bad++; $display("FAIL pack_drained: got vld=%b lvl=%0d want 0/0", obs_vld, obs_lvl); end
  endtask

  task automatic test_backpressure();
    logic [3:0] nibs [10];
    int guard;
    for (int i = 0; i < 10; i++) nibs[i] = 4'($urandom_range(0, 15));
    acc_q.delete();
    popped_q.delete();
    for (int i = 0; i < 20; i++) begin
      step(acc_q.size() < 10, nibs[acc_q.size() < 10 ? acc_q.size() : 0], 0, 0);
      tot++; if (obs_rdy !== exp_rdy) begin bad++; $display("FAIL bp_in_ready: got %b want %b", obs_rdy, exp_rdy); end
      tot++; if (obs_lvl !== exp_lvl) begin bad++; $display("FAIL bp_level: got %0d want %0d", obs_lvl, exp_lvl); end
    end
    tot++; if (bus.level !== LW'(4)) begin bad++; $display("FAIL bp_full_level: got %0d want 4", bus.level); end
    tot++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_half_blocked: got %b want 0", bus.in_ready); end
    tot++; if (acc_q.size() != 9) begin bad++; $display("FAIL bp_accepted: got %0d want 9", acc_q.size()); end
    guard = 0;
    while (popped_q.size() < 5 && guard < 100) begin
      step(acc_q.size() < 10, nibs[acc_q.size() < 10 ? acc_q.size() : 0], 0, 1);
      tot++; if (obs_dat !== exp_dat || obs_vld !== exp_vld) begin bad++; $display("FAIL bp_head: got %b/%h want %b/%h", obs_vld, obs_dat, exp_vld, exp_dat); end
      guard++;
    end
    tot++; if (popped_q.size() != 5) begin bad++; $display("FAIL bp_drain_timeout: got %0d bytes want 5", popped_q.size()); end
    for (int k = 0; k < 5 && k < popped_q.size(); k++) begin
      tot++; if (popped_q[k] !== {nibs[2*k+1], nibs[2*k]}) begin bad++; $display("FAIL bp_order[%0d]: got %h want %h", k, popped_q[k], {nibs[2*k+1], nibs[2*k]}); end
    end
  endtask

  task automatic test_flush();
    step(1, 4'hF, 0, 1);
    step(0, 4'h0, 1, 1);
    step(0, 4'h0, 0, 1);
    tot++; if (obs_vld !== 1'b1 || obs_dat !== 8'h0F) begin bad++; $display("FAIL flush_pad: got %b/%h want 1/0f", obs_vld, obs_dat); end
    step(0, 4'h0, 1, 1);
    step(0, 4'h0, 0, 1);
    tot++; if (obs_lvl !== '0 || obs_vld !== 1'b0) begin bad++; $display("FAIL flush_empty_ignored: got lvl=%0d vld=%b want 0/0", obs_lvl, obs_vld); end
    popped_q.delete();
    for (int i = 0; i < 8; i++) step(1, 4'(i), 0, 0);
    step(1, 4'h1, 0, 0);
    step(0, 4'h0, 1, 0);
    step(0, 4'h0, 0, 0);
    tot++; if (obs_rdy !== 1'b0) begin bad++; $display("FAIL flush_pend_ready: got %b want 0", obs_rdy); end
    tot++; if (obs_lvl !== LW'(4)) begin bad++; $display("FAIL flush_full_level: got %0d want 4", obs_lvl); end
    step(1, 4'h3, 0, 1);
    for (int i = 0; i < 12 && popped_q.size() < 5; i++) begin
      step(0, 4'h0, 0, 1);
      tot++; if (obs_dat !== exp_dat || obs_lvl !== exp_lvl) begin bad++; $display("FAIL flush_drain: got %h/%0d want %h/%0d", obs_dat, obs_lvl, exp_dat, exp_lvl); end
    end
    tot++; if (popped_q.size() != 5 || popped_q[popped_q.size()-1] !== 8'h01) begin bad++; $display("FAIL flush_full_pad: got n=%0d want last byte 01", popped_q.size()); end
  endtask

  task automatic test_wrap();
    int guard, cover_steady;
    acc_q.delete();
    popped_q.delete();
    guard        = 0;
    cover_steady = 0;
    while (popped_q.size() < 20 && guard < 2000) begin
      step(acc_q.size() < 40 && ($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), 0, $urandom_range(0, 9) < 6);
      tot++; if (obs_vld !== exp_vld || obs_dat !== exp_dat) begin bad++; $display("FAIL wrap_head: got %b/%h want %b/%h", obs_vld, obs_dat, exp_vld, exp_dat); end
      tot++; if (obs_lvl !== exp_lvl || obs_rdy !== exp_rdy) begin bad++; $display("FAIL wrap_lvl_rdy: got %0d/%b want %0d/%b", obs_lvl, obs_rdy, exp_lvl, exp_rdy); end
`ifdef NIBBLE_PACK_PARITY_EN
      tot++; if (obs_par !== exp_par) begin bad++; $display("FAIL wrap_parity: got %b want %b", obs_par, exp_par); end
`endif
      if (last_push && last_out_fire) cover_steady++;
      guard++;
    end
    tot++; if (popped_q.size() != 20) begin bad++; $display("FAIL wrap_timeout: got %0d bytes want 20", popped_q.size()); end
    tot++; if (cover_steady == 0) begin bad++; $display("FAIL wrap_cover_push_pop: got 0 want >0"); end
    for (int k = 0; k < popped_q.size(); k++) begin
      tot++; if (popped_q[k] !== {acc_q[2*k+1], acc_q[2*k]}) begin bad++; $display("FAIL wrap_order[%0d]: got %h want %h", k, popped_q[k], {acc_q[2*k+1], acc_q[2*k]}); end
    end
    for (int i = 0; i < 8; i++) step(0, 4'h0, 0, 1);
  endtask

  task automatic test_midop_reset();
    for (int i = 0; i < 7; i++) step(1, 4'(i + 6), 0, 0);
    tot++; if (bus.level !== LW'(3)) begin bad++; $display("FAIL mid_level_before: got %0d want 3", bus.level); end
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    tot++; if (bus.level !== '0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_clear: got lvl=%0d vld=%b want 0/0", bus.level, bus.out_valid); end
    step(1, 4'h1, 0, 1);
    step(1, 4'h2, 0, 1);
    step(0, 4'h0, 0, 1);
    tot++; if (obs_vld !== 1'b1 || obs_dat !== 8'h21) begin bad++; $display("FAIL mid_first_byte: got %b/%h want 1/21", obs_vld, obs_dat); end
    step(0, 4'h0, 0, 1);
  endtask

`ifdef NIBBLE_PACK_PARITY_EN
  task automatic test_parity();
    step(1, 4'h5, 0, 1);
    step(1, 4'hA, 0, 1);
    step(0, 4'h0, 0, 1);
    tot++; if (obs_dat !== 8'hA5 || obs_par !== 1'b0) begin bad++; $display("FAIL par_a5: got %h/%b want a5/0", obs_dat, obs_par); end
    step(1, 4'hF, 0, 1);
    step(0, 4'h0, 1, 1);
    step(0, 4'h0, 0, 1);
    tot++; if (obs_dat !== 8'h0F || obs_par !== 1'b0) begin bad++; $display("FAIL par_0f: got %h/%b want 0f/0", obs_dat, obs_par); end
    step(1, 4'h7, 0, 1);
    step(0, 4'h0, 1, 1);
    step(0, 4'h0, 0, 1);
    tot++; if (obs_dat !== 8'h07 || obs_par !== 1'b1) begin bad++; $display("FAIL par_07: got %h/%b want 07/1", obs_dat, obs_par); end
    step(0, 4'h0, 0, 1);
    tot++; if (obs_par !== 1'b0) begin bad++; $display("FAIL par_idle: got %b want 0", obs_par); end
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();
    test_reset();
    test_pack();
    test_backpressure();
    test_flush();
    test_wrap();
    test_midop_reset();
`ifdef NIBBLE_PACK_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
